// File: rtl/irq_ctrl_pkg.sv
// Shared register map and FSM encoding for the external interrupt controller.
package irq_ctrl_pkg;

    localparam logic [3:0] IRQ_IE    = 4'h0;
    localparam logic [3:0] IRQ_PEND  = 4'h4;
    localparam logic [3:0] IRQ_EDGE  = 4'h8;
    localparam logic [3:0] IRQ_CLAIM = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register port plus core external-trap handshake; _i/_o are seen from the controller.
interface irq_ctrl_if;

    logic [3:0]  reg_addr_i;
    logic        reg_we_i;
    logic        reg_re_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        ex_trap_valid_o;
    logic        ex_trap_ready_i;
    logic [4:0]  irq_id_o;

    modport master (
        output reg_addr_i, reg_we_i, reg_re_i, reg_wdata_i, ex_trap_ready_i,
        input  reg_rdata_o, ex_trap_valid_o, irq_id_o
    );

    modport slave (
        input  reg_addr_i, reg_we_i, reg_re_i, reg_wdata_i, ex_trap_ready_i,
        output reg_rdata_o, ex_trap_valid_o, irq_id_o
    );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational, no handshake.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         any_o,
    output logic [4:0]   idx_o
);

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_o = 1'b1;
                idx_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: synchronise, latch level/edge pending, mask, prioritise, trap handshake.
// Valid rises SYNC_STAGES+2 cycles after a line; no nesting until software writes CLAIM.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int IRQ_NUM     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq_i,
    irq_ctrl_if.slave          bus
);

    logic [IRQ_NUM-1:0] irq_s, irq_d_q;
    logic [IRQ_NUM-1:0] ie_q, edge_q, pend_q, pend_d;
    logic [IRQ_NUM-1:0] req, clr, win_oh;
    logic [4:0]         win, id_q;
    logic               any, take, valid_q;
    logic               wr_ie, wr_pend, wr_edge, wr_claim;
    logic [31:0]        rd_val, rdata_q;
    irq_state_t         state_q;
    logic               unused_wdata;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [IRQ_NUM-1:0] q;
        if (g == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) q <= '0;
                else     q <= irq_i;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (rst) q <= '0;
                else     q <= g_sync[g-1].q;
            end
        end
    end
    assign irq_s = g_sync[SYNC_STAGES-1].q;

    assign wr_ie    = bus.reg_we_i && (bus.reg_addr_i == IRQ_IE);
    assign wr_pend  = bus.reg_we_i && (bus.reg_addr_i == IRQ_PEND);
    assign wr_edge  = bus.reg_we_i && (bus.reg_addr_i == IRQ_EDGE);
    assign wr_claim = bus.reg_we_i && (bus.reg_addr_i == IRQ_CLAIM);
    assign unused_wdata = ^bus.reg_wdata_i[31:IRQ_NUM];

    assign req = pend_q & ie_q;

    irq_prio_enc #(.N(IRQ_NUM)) u_prio_enc (
        .req_i (req),
        .any_o (any),
        .idx_o (win)
    );

    assign take   = (state_q == ST_REQ) && bus.ex_trap_ready_i && any;
    assign win_oh = IRQ_NUM'(1) << win;

    // Edge bits: a fresh edge overrides a same-cycle clear; level bits just track the line.
    always_comb begin
        clr    = ({IRQ_NUM{take}} & win_oh)
               | ({IRQ_NUM{wr_pend}} & bus.reg_wdata_i[IRQ_NUM-1:0]);
        pend_d = (edge_q & ((irq_s & ~irq_d_q) | (pend_q & ~clr)))
               | (~edge_q & irq_s);
    end

    always_comb begin
        case (bus.reg_addr_i)
            IRQ_IE:    rd_val = 32'(ie_q);
            IRQ_PEND:  rd_val = 32'(pend_q);
            IRQ_EDGE:  rd_val = 32'(edge_q);
            IRQ_CLAIM: rd_val = 32'(id_q);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d_q <= '0;
            ie_q    <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            rdata_q <= '0;
        end else begin
            irq_d_q <= irq_s;
            pend_q  <= pend_d;
            if (wr_ie)          ie_q    <= bus.reg_wdata_i[IRQ_NUM-1:0];
            if (wr_edge)        edge_q  <= bus.reg_wdata_i[IRQ_NUM-1:0];
            if (bus.reg_re_i)   rdata_q <= rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        state_q <= ST_REQ;
                        valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Winner is taken at acceptance time, so a later higher-priority source wins.
                    if (take) begin
                        state_q <= ST_BUSY;
                        valid_q <= 1'b0;
                        id_q    <= win + 5'd1;
                    end else if (!any) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (wr_claim) begin
                        state_q <= ST_IDLE;
                        id_q    <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ex_trap_valid_o = valid_q;
    assign bus.irq_id_o        = id_q;
    assign bus.reg_rdata_o     = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl, checked against a behavioural model every cycle.
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int SY = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;

    irq_ctrl_if bus ();

    irq_ctrl #(.IRQ_NUM(N), .SYNC_STAGES(SY)) dut (
        .clk   (clk),
        .rst   (rst),
        .irq_i (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model state: what software and the core should observe.
    bit [N-1:0]  m_ie, m_edge, m_pend;
    bit          m_valid, m_busy;
    int          m_id;
    logic [31:0] m_rdata;
    bit [N-1:0]  hist[$];   // hist[k] = line value sampled k+1 edges ago

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ie = '0; m_edge = '0; m_pend = '0;
        m_valid = 1'b0; m_busy = 1'b0; m_id = 0; m_rdata = '0;
        hist.delete();
        for (int i = 0; i <= SY; i++) hist.push_back('0);
    endfunction

    task automatic tick();
        bit [N-1:0]  s, d, rise, np, nie, nedge, cur_irq;
        bit          take, nvalid, nbusy, do_rst, we, re, rdy;
        int          win, nid;
        logic [3:0]  a;
        logic [31:0] wd, nrd;
        do_rst = rst; we = bus.reg_we_i; re = bus.reg_re_i; rdy = bus.ex_trap_ready_i;
        a = bus.reg_addr_i; wd = bus.reg_wdata_i; cur_irq = irq;
        s = hist[SY-1]; d = hist[SY]; rise = s & ~d;
        win = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && m_ie[i] && win < 0) win = i;
        take = m_valid && rdy && (win >= 0);
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) np[i] = rise[i] || (m_pend[i] && !((take && win == i) || (we && a == 4'h4 && wd[i])));
            else           np[i] = s[i];
        end
        nie   = (we && a == 4'h0) ? wd[N-1:0] : m_ie;
        nedge = (we && a == 4'h8) ? wd[N-1:0] : m_edge;
        nrd = m_rdata;
        if (re) begin
            case (a)
                4'h0:    nrd = 32'(m_ie);
                4'h4:    nrd = 32'(m_pend);
                4'h8:    nrd = 32'(m_edge);
                4'hC:    nrd = 32'(m_id);
                default: nrd = '0;
            endcase
        end
        nvalid = m_valid; nbusy = m_busy; nid = m_id;
        if (m_busy) begin
            if (we && a == 4'hC) begin nbusy = 1'b0; nid = 0; end
        end else if (m_valid) begin
            if (take) begin nid = win + 1; nbusy = 1'b1; nvalid = 1'b0; end
            else if (win < 0) nvalid = 1'b0;
        end else if (win >= 0) begin
            nvalid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            model_reset();
        end else begin
            m_pend = np; m_ie = nie; m_edge = nedge; m_rdata = nrd;
            m_valid = nvalid; m_busy = nbusy; m_id = nid;
            hist.push_front(cur_irq);
            void'(hist.pop_back());
        end
        check("cyc_valid", 32'(bus.ex_trap_valid_o), 32'(m_valid));
        check("cyc_id",    32'(bus.irq_id_o), 32'(m_id));
        check("cyc_rdata", bus.reg_rdata_o, m_rdata);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(logic [3:0] a, logic [31:0] dat);
        bus.reg_we_i = 1'b1; bus.reg_addr_i = a; bus.reg_wdata_i = dat;
        tick();
        bus.reg_we_i = 1'b0;
    endtask

    task automatic rd(logic [3:0] a, output logic [31:0] v);
        bus.reg_re_i = 1'b1; bus.reg_addr_i = a;
        tick();
        bus.reg_re_i = 1'b0;
        v = bus.reg_rdata_o;
    endtask

    task automatic ready_pulse();
        bus.ex_trap_ready_i = 1'b1;
        tick();
        bus.ex_trap_ready_i = 1'b0;
    endtask

    task automatic wait_valid(string tag);
        int n = 0;
        while (!bus.ex_trap_valid_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.ex_trap_valid_o), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; irq = '0;
        bus.reg_addr_i = '0; bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0;
        bus.reg_wdata_i = '0; bus.ex_trap_ready_i = 1'b0;
        model_reset();
        ticks(2);
        rst = 1'b0;
        check("rst_valid", 32'(bus.ex_trap_valid_o), 32'd0);
        check("rst_id", 32'(bus.irq_id_o), 32'd0);
        check("rst_rdata", bus.reg_rdata_o, 32'd0);

        // Level source, latency and claim readback
        wr(4'h0, 32'h01);
        irq = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("lvl_latency", 32'(bus.ex_trap_valid_o), (k == 4) ? 32'd1 : 32'd0);
        end
        irq = '0;
        ready_pulse();
        check("lvl_id", 32'(bus.irq_id_o), 32'd1);
        check("lvl_valid_low", 32'(bus.ex_trap_valid_o), 32'd0);
        rd(4'hC, v);
        check("lvl_claim_rd", v, 32'd1);
        ticks(4);
        wr(4'hC, 32'd0);
        ticks(3);
        check("lvl_idle_valid", 32'(bus.ex_trap_valid_o), 32'd0);
        check("lvl_idle_id", 32'(bus.irq_id_o), 32'd0);

        // Fixed priority among simultaneous edges
        wr(4'h0, 32'hFF);
        wr(4'h8, 32'hFF);
        irq = 8'h24; tick(); irq = '0;
        wait_valid("pri_valid");
        ready_pulse();
        check("pri_id", 32'(bus.irq_id_o), 32'd3);
        rd(4'h4, v);
        check("pri_pend", v, 32'h20);
        wr(4'hC, 32'd0);
        wait_valid("pri_rearm");
        ready_pulse();
        check("pri_id2", 32'(bus.irq_id_o), 32'd6);
        wr(4'hC, 32'd0);
        ticks(2);
        check("pri_idle", 32'(bus.ex_trap_valid_o), 32'd0);

        // Edge captured while busy, no nesting until claim
        irq = 8'h10; tick(); irq = '0;
        wait_valid("bsy_valid");
        ready_pulse();
        check("bsy_id", 32'(bus.irq_id_o), 32'd5);
        irq = 8'h02; tick(); irq = '0;
        ticks(4);
        check("bsy_hold", 32'(bus.ex_trap_valid_o), 32'd0);
        rd(4'h4, v);
        check("bsy_pend", v, 32'h02);
        wr(4'hC, 32'd0);
        tick();
        check("bsy_rearm", 32'(bus.ex_trap_valid_o), 32'd1);
        ready_pulse();
        check("bsy_id2", 32'(bus.irq_id_o), 32'd2);
        wr(4'hC, 32'd0);

        // Level withdrawal before acceptance
        wr(4'h8, 32'h00);
        irq = 8'h08;
        wait_valid("wd_valid");
        irq = '0;
        ticks(3);
        check("wd_still", 32'(bus.ex_trap_valid_o), 32'd1);
        tick();
        check("wd_drop", 32'(bus.ex_trap_valid_o), 32'd0);
        ready_pulse();
        check("wd_ign_id", 32'(bus.irq_id_o), 32'd0);
        check("wd_ign_valid", 32'(bus.ex_trap_valid_o), 32'd0);

        // Same-cycle set and write-1 clear on an edge bit
        wr(4'h8, 32'hFF);
        irq = 8'h04; tick(); irq = '0; tick();
        wr(4'h4, 32'h04);
        rd(4'h4, v);
        check("clash_pend", v, 32'h04);
        wait_valid("clash_valid");
        ready_pulse();
        check("clash_id", 32'(bus.irq_id_o), 32'd3);
        irq = 8'h04; tick(); irq = '0;
        ticks(3);
        rd(4'h4, v);
        check("w1c_before", v, 32'h04);
        wr(4'h4, 32'h04);
        rd(4'h4, v);
        check("w1c_after", v, 32'h00);
        rd(4'h0, v);
        check("ie_readback", v, 32'hFF);

        // Reset while busy
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstb_valid", 32'(bus.ex_trap_valid_o), 32'd0);
        check("rstb_id", 32'(bus.irq_id_o), 32'd0);
        check("rstb_rdata", bus.reg_rdata_o, 32'd0);
        rd(4'h0, v); check("rstb_ie", v, 32'd0);
        rd(4'h4, v); check("rstb_pend", v, 32'd0);
        rd(4'h8, v); check("rstb_edge", v, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq = N'($urandom);
            bus.reg_we_i        = ($urandom_range(0, 7) == 0);
            bus.reg_re_i        = ($urandom_range(0, 3) == 0);
            bus.reg_addr_i      = 4'($urandom);
            if ($urandom_range(0, 3) != 0) bus.reg_addr_i[1:0] = 2'b00;
            bus.reg_wdata_i     = $urandom;
            bus.ex_trap_ready_i = ($urandom_range(0, 2) == 0);
            rst                 = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0; bus.ex_trap_ready_i = 1'b0;
        rst = 1'b0; irq = '0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
